control_unit: RTL

// Multi-cycle FSM sequencer for the accumulator datapath (PC, IR, ACC, ALU, data memory, status register).

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/branch_cond.sv | 25 ++
 rtl/control_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer states, ALU op codes.
// Used by the control unit, the ALU and the decoder-side datapath.
package cpu_pkg;

  typedef enum logic [4:0] {
    OP_HLT  = 5'd0,
    OP_STO  = 5'd1,
    OP_LD   = 5'd2,
    OP_LDI  = 5'd3,
    OP_ADD  = 5'd4,
    OP_ADDI = 5'd5,
    OP_SUB  = 5'd6,
    OP_SUBI = 5'd7,
    OP_BEQ  = 5'd8,
    OP_BNE  = 5'd9,
    OP_BGT  = 5'd10,
    OP_BGE  = 5'd11,
    OP_BLT  = 5'd12,
    OP_BLE  = 5'd13,
    OP_JMP  = 5'd14,
    OP_NOP  = 5'd15
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch resolver: decides whether a branch opcode is taken from the Z/N flags.
// Non-branch opcodes always report not-taken.
module branch_cond
  import cpu_pkg::*;
(
  input  opcode_t op,
  input  logic    flag_Z,
  input  logic    flag_N,
  output logic    take
);

  always_comb begin
    take = 1'b0;
    case (op)
      OP_BEQ:  take = flag_Z;
      OP_BNE:  take = !flag_Z;
      OP_BGT:  take = !flag_Z && !flag_N;
      OP_BGE:  take = !flag_N;
      OP_BLT:  take = flag_N;
      OP_BLE:  take = flag_Z || flag_N;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the accumulator datapath.
// Drives every datapath enable and mux select from the state and the latched opcode.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    status_reset,
  input  logic [OPCODE_WIDTH-1:0] opcode_in,
  input  logic                    flag_Z,
  input  logic                    flag_N,
  output logic                    pc_wr,
  output logic                    pc_src,
  output logic                    ir_wr,
  output logic                    mem_wr,
  output logic                    acc_wr,
  output logic                    status_wr,
  output logic [1:0]              alu_op,
  output logic                    b_sel,
  output logic                    halted
);

  state_t  state_reg, state_next;
  opcode_t op_reg, op_next;
  logic    take;

  branch_cond u_branch_cond (
    .op     (op_reg),
    .flag_Z (flag_Z),
    .flag_N (flag_N),
    .take   (take)
  );

  always_ff @(posedge clock or posedge status_reset) begin
    if (status_reset) begin
      state_reg <= ST_FETCH;
      op_reg    <= OP_NOP;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    case (state_reg)
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
        // Codes beyond JMP all collapse to NOP
        op_next    = (opcode_in < OPCODE_WIDTH'(15)) ? opcode_t'(5'(opcode_in)) : OP_NOP;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (op_reg)
          OP_HLT:                         state_next = ST_HALT;
          OP_LD, OP_LDI, OP_ADD, OP_ADDI,
          OP_SUB, OP_SUBI:                state_next = ST_WB;
          default:                        state_next = ST_FETCH;
        endcase
      end
      ST_WB:     state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_wr     = 1'b0;
    pc_src    = 1'b0;
    ir_wr     = 1'b0;
    mem_wr    = 1'b0;
    acc_wr    = 1'b0;
    status_wr = 1'b0;
    alu_op    = ALU_PASS;
    b_sel     = 1'b0;
    halted    = 1'b0;
    // Gating on the reset input makes enables drop the moment reset is raised
    if (!status_reset) begin
      if (state_reg == ST_EXEC || state_reg == ST_WB) begin
        case (op_reg)
          OP_LDI:  b_sel = 1'b1;
          OP_ADD:  alu_op = ALU_ADD;
          OP_ADDI: begin alu_op = ALU_ADD; b_sel = 1'b1; end
          OP_SUB:  alu_op = ALU_SUB;
          OP_SUBI: begin alu_op = ALU_SUB; b_sel = 1'b1; end
          default: ;
        endcase
      end
      case (state_reg)
        ST_FETCH: begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
        ST_EXEC: begin
          case (op_reg)
            OP_STO: mem_wr = 1'b1;
            OP_JMP: begin pc_wr = 1'b1; pc_src = 1'b1; end
            OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE: begin
              pc_wr  = take;
              pc_src = 1'b1;
            end
            default: ;
          endcase
        end
        ST_WB: begin
          acc_wr    = 1'b1;
          status_wr = 1'b1;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
